// File: rtl/coram_channel.sv
// rtl/coram_channel.sv - CoRAM channel: independent user<->thread up/down FIFOs (optional CORAM_CHANNEL_COUNT_EN adds occupancy outputs)

module coram_channel_fifo #(
  parameter int ADDR_LEN   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  push_i,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  pop_i,
  output logic                  empty_o
`ifdef CORAM_CHANNEL_COUNT_EN
  ,
  output logic [ADDR_LEN:0]     count_o
`endif
);

  localparam int DEPTH = 1 << ADDR_LEN;

  logic [ADDR_LEN:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_LEN:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push_ok, pop_ok;

  // Extra pointer MSB tells a full queue apart from an empty one.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[ADDR_LEN-1:0] == rd_ptr_q[ADDR_LEN-1:0]) &&
                   (wr_ptr_q[ADDR_LEN] != rd_ptr_q[ADDR_LEN]);

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = rdata_q;

`ifdef CORAM_CHANNEL_COUNT_EN
  assign count_o = wr_ptr_q - rd_ptr_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_q[rd_ptr_q[ADDR_LEN-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is not reset; its contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[ADDR_LEN-1:0]] <= wdata_i;
    end
  end

endmodule

module coram_channel #(
  parameter CORAM_THREAD_NAME = "undefined",
  parameter CORAM_ID          = 0,
  parameter CORAM_ADDR_LEN    = 4,
  parameter CORAM_DATA_WIDTH  = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CORAM_DATA_WIDTH-1:0] D,
  input  logic                        ENQ,
  output logic                        FULL,
  output logic [CORAM_DATA_WIDTH-1:0] Q,
  input  logic                        DEQ,
  output logic                        EMPTY,
  input  logic [CORAM_DATA_WIDTH-1:0] THREAD_D,
  input  logic                        THREAD_ENQ,
  output logic                        THREAD_FULL,
  output logic [CORAM_DATA_WIDTH-1:0] THREAD_Q,
  input  logic                        THREAD_DEQ,
  output logic                        THREAD_EMPTY
`ifdef CORAM_CHANNEL_COUNT_EN
  ,
  output logic [CORAM_ADDR_LEN:0]     COUNT,
  output logic [CORAM_ADDR_LEN:0]     THREAD_COUNT
`endif
);

  // Identification parameters only; this empty block keeps them referenced.
  if ((CORAM_ID < 0) || ($bits(CORAM_THREAD_NAME) < 8)) begin : g_identity_unused
  end

  coram_channel_fifo #(
    .ADDR_LEN   (CORAM_ADDR_LEN),
    .DATA_WIDTH (CORAM_DATA_WIDTH)
  ) u_up_fifo (
    .clk_i   (CLK),
    .rstn_i  (RST),
    .wdata_i (D),
    .push_i  (ENQ),
    .full_o  (FULL),
    .rdata_o (THREAD_Q),
    .pop_i   (THREAD_DEQ),
`ifdef CORAM_CHANNEL_COUNT_EN
    .empty_o (THREAD_EMPTY),
    .count_o (COUNT)
`else
    .empty_o (THREAD_EMPTY)
`endif
  );

  coram_channel_fifo #(
    .ADDR_LEN   (CORAM_ADDR_LEN),
    .DATA_WIDTH (CORAM_DATA_WIDTH)
  ) u_down_fifo (
    .clk_i   (CLK),
    .rstn_i  (RST),
    .wdata_i (THREAD_D),
    .push_i  (THREAD_ENQ),
    .full_o  (THREAD_FULL),
    .rdata_o (Q),
    .pop_i   (DEQ),
`ifdef CORAM_CHANNEL_COUNT_EN
    .empty_o (EMPTY),
    .count_o (THREAD_COUNT)
`else
    .empty_o (EMPTY)
`endif
  );

endmodule

// File: tb/tb_coram_channel.sv
// tb/tb_coram_channel.sv - table-driven and scoreboard checks for coram_channel

module tb_coram_channel;

  localparam int AL    = 4;
  localparam int W     = 32;
  localparam int DEPTH = 1 << AL;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] D, THREAD_D;
  logic         ENQ, DEQ, THREAD_ENQ, THREAD_DEQ;
  logic         FULL, EMPTY, THREAD_FULL, THREAD_EMPTY;
  logic [W-1:0] Q, THREAD_Q;
`ifdef CORAM_CHANNEL_COUNT_EN
  logic [AL:0]  COUNT, THREAD_COUNT;
`endif

  always #5 CLK = ~CLK;

  coram_channel #(
    .CORAM_THREAD_NAME ("tb_thread"),
    .CORAM_ID          (0),
    .CORAM_ADDR_LEN    (AL),
    .CORAM_DATA_WIDTH  (W)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .D            (D),
    .ENQ          (ENQ),
    .FULL         (FULL),
    .Q            (Q),
    .DEQ          (DEQ),
    .EMPTY        (EMPTY),
    .THREAD_D     (THREAD_D),
    .THREAD_ENQ   (THREAD_ENQ),
    .THREAD_FULL  (THREAD_FULL),
    .THREAD_Q     (THREAD_Q),
    .THREAD_DEQ   (THREAD_DEQ),
`ifdef CORAM_CHANNEL_COUNT_EN
    .THREAD_EMPTY (THREAD_EMPTY),
    .COUNT        (COUNT),
    .THREAD_COUNT (THREAD_COUNT)
`else
    .THREAD_EMPTY (THREAD_EMPTY)
`endif
  );

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [W-1:0] up_q[$];
  logic [W-1:0] dn_q[$];
  logic [W-1:0] exp_q, exp_tq;

  typedef struct {
    logic         enq;
    logic [W-1:0] d;
    logic         tdeq;
    logic         tenq;
    logic [W-1:0] td;
    logic         deq;
    logic [W-1:0] q;
    logic [W-1:0] tq;
    logic         empty;
    logic         tempty;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("Q", Q, exp_q);
    chk("THREAD_Q", THREAD_Q, exp_tq);
    chk("EMPTY", W'(EMPTY), W'(dn_q.size() == 0));
    chk("THREAD_FULL", W'(THREAD_FULL), W'(dn_q.size() == DEPTH));
    chk("THREAD_EMPTY", W'(THREAD_EMPTY), W'(up_q.size() == 0));
    chk("FULL", W'(FULL), W'(up_q.size() == DEPTH));
`ifdef CORAM_CHANNEL_COUNT_EN
    chk("COUNT", W'(COUNT), W'(up_q.size()));
    chk("THREAD_COUNT", W'(THREAD_COUNT), W'(dn_q.size()));
`endif
  endtask

  task automatic idle_inputs();
    ENQ = 1'b0; D = '0; THREAD_DEQ = 1'b0;
    THREAD_ENQ = 1'b0; THREAD_D = '0; DEQ = 1'b0;
  endtask

  // One clock: drive, predict acceptance from current occupancy, update model, compare.
  task automatic step(input logic enq, input logic [W-1:0] d, input logic tdeq,
                      input logic tenq, input logic [W-1:0] td, input logic deq);
    bit up_push, up_pop, dn_push, dn_pop;
    @(negedge CLK);
    ENQ = enq; D = d; THREAD_DEQ = tdeq;
    THREAD_ENQ = tenq; THREAD_D = td; DEQ = deq;
    up_push = enq && (up_q.size() < DEPTH);
    up_pop  = tdeq && (up_q.size() != 0);
    dn_push = tenq && (dn_q.size() < DEPTH);
    dn_pop  = deq && (dn_q.size() != 0);
    @(posedge CLK);
    #1;
    idle_inputs();
    if (up_pop)  exp_tq = up_q.pop_front();
    if (up_push) up_q.push_back(d);
    if (dn_pop)  exp_q = dn_q.pop_front();
    if (dn_push) dn_q.push_back(td);
    check_all();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    RST = 1'b0;
    repeat (cycles) @(posedge CLK);
    #1;
    RST = 1'b1;
    up_q.delete();
    dn_q.delete();
    exp_q  = '0;
    exp_tq = '0;
    check_all();
  endtask

  initial begin
    RST = 1'b0;
    idle_inputs();
    exp_q  = '0;
    exp_tq = '0;

    //        enq d      tdeq tenq td        deq q          tq      empty tempty
    vecs[0] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0,  1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h0,  1'b1, 1'b1};
    vecs[2] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h0,  1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h11, 1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 32'h0,  1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h22, 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 32'h11, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 32'h22, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 32'h22, 1'b1, 1'b1};

    do_reset(2);

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].enq, vecs[i].d, vecs[i].tdeq, vecs[i].tenq, vecs[i].td, vecs[i].deq);
      chk($sformatf("tbl%0d_Q", i), Q, vecs[i].q);
      chk($sformatf("tbl%0d_THREAD_Q", i), THREAD_Q, vecs[i].tq);
      chk($sformatf("tbl%0d_EMPTY", i), W'(EMPTY), W'(vecs[i].empty));
      chk($sformatf("tbl%0d_THREAD_EMPTY", i), W'(THREAD_EMPTY), W'(vecs[i].tempty));
    end

    // Fill the up queue, overflow attempts, push+pop while full, drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i), 1'b0, 1'b0, '0, 1'b0);
    chk("fill_full", W'(FULL), 1);
    step(1'b1, 32'hFF, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'hEE, 1'b1, 1'b0, '0, 1'b0);
    chk("full_pop_head", THREAD_Q, 0);
    for (int i = 1; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("fill_last", THREAD_Q, 15);
    chk("fill_drained", W'(THREAD_EMPTY), 1);

    // Simultaneous push and pop on the down queue holding three words.
    for (int i = 1; i <= 3; i++) step(1'b0, '0, 1'b0, 1'b1, W'(i), 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 32'hAA, 1'b1);
    chk("simul_head", Q, 1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("simul_fourth", Q, 32'hAA);
    chk("simul_empty", W'(EMPTY), 1);

    // Underflow, then streaming pairs across pointer wrap on both queues.
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("underflow_hold", Q, 32'hAA);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, $urandom, 1'b1, 1'b1, $urandom, 1'b1);
    end

    // Reset with words in flight discards them.
    for (int i = 0; i < 5; i++) step(1'b1, W'(i + 8), 1'b0, 1'b1, W'(i + 16), 1'b0);
    do_reset(1);
    chk("rst_mid_empty", W'(EMPTY), 1);
    chk("rst_mid_q", Q, 0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h55, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("rst_mid_new", Q, 32'h55);
    chk("rst_mid_empty2", W'(EMPTY), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/coram_channel.md
CORAM_CHANNEL -- requirements
Module: coram_channel

Interface
REQ-001 SHALL have parameter CORAM_THREAD_NAME, default "undefined", naming the control thread that owns the channel (identification only, no RTL effect).
REQ-002 SHALL have parameter CORAM_ID, default 0, giving the channel index within the thread (identification only).
REQ-003 SHALL have parameter CORAM_ADDR_LEN, default 4; each direction's queue depth is 2**CORAM_ADDR_LEN words.
REQ-004 SHALL have parameter CORAM_DATA_WIDTH, default 32, giving the word width W.
REQ-005 SHALL have port CLK  input  1  single clock; all logic rises on posedge CLK.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port D  input  W  user-to-thread write data.
REQ-008 SHALL have port ENQ  input  1  user push request into the up queue.
REQ-009 SHALL have port FULL  output  1  up queue holds 2**CORAM_ADDR_LEN words.
REQ-010 SHALL have port Q  output  W  registered thread-to-user read data.
REQ-011 SHALL have port DEQ  input  1  user pop request from the down queue.
REQ-012 SHALL have port EMPTY  output  1  down queue holds 0 words.
REQ-013 SHALL have port THREAD_D  input  W  thread-to-user write data.
REQ-014 SHALL have port THREAD_ENQ  input  1  thread push request into the down queue.
REQ-015 SHALL have port THREAD_FULL  output  1  down queue full.
REQ-016 SHALL have port THREAD_Q  output  W  registered user-to-thread read data.
REQ-017 SHALL have port THREAD_DEQ  input  1  thread pop request from the up queue.
REQ-018 SHALL have port THREAD_EMPTY  output  1  up queue empty.

Function
REQ-019 SHALL implement two independent FIFOs.
- Up queue: pushed by D/ENQ, popped by THREAD_DEQ.
- Down queue: pushed by THREAD_D/THREAD_ENQ, popped by DEQ.
- Both use identical logic: CORAM_ADDR_LEN+1-bit read and write pointers, and a 2**CORAM_ADDR_LEN x W storage array.
REQ-020 SHALL accept a push at a clock edge only when the push request is 1 and the queue's full flag is 0; a push while full SHALL be ignored and SHALL NOT change data, pointers or flags.
REQ-021 SHALL accept a pop at a clock edge only when the pop request is 1 and the queue's empty flag is 0; a pop while empty SHALL be ignored, and the read-data output SHALL hold its value.
REQ-022 SHALL load the head word into the read-data register (Q or THREAD_Q) at the edge that accepts a pop, so data is valid the cycle after DEQ is sampled; Q SHALL hold that value until the next accepted pop.
REQ-023 SHALL derive the flags combinationally from the registered pointers.
- Empty: the two pointers are equal.
- Full: the address bits are equal and the MSBs differ.
- Flags therefore update in the cycle after the accepted push or pop.
REQ-024 SHALL allow a push and a pop to be accepted at the same edge; occupancy is then unchanged and the popped word is the old head.
REQ-025 SHALL NOT bypass data: a push into an empty queue becomes poppable only from the next cycle.
REQ-026 SHALL wrap pointers modulo 2**(CORAM_ADDR_LEN+1) so every depth slot is usable, and SHALL preserve FIFO ordering across wrap-around.
REQ-027 SHALL pass W-bit words unmodified, with no arithmetic on the data.

Reset
REQ-028 SHALL, on any edge with RST=0, clear all four pointers and set Q=0 and THREAD_Q=0.
- Resulting flags: EMPTY=1, THREAD_EMPTY=1, FULL=0, THREAD_FULL=0.
- Storage contents are don't-care.
REQ-029 SHALL give reset priority over simultaneous push or pop requests; any in-flight contents SHALL be discarded.

Configuration
REQ-030 SHALL, when macro CORAM_CHANNEL_COUNT_EN is defined, add two outputs:
- COUNT, CORAM_ADDR_LEN+1 bits, up-queue occupancy.
- THREAD_COUNT, CORAM_ADDR_LEN+1 bits, down-queue occupancy.
- Both equal write pointer minus read pointer and read 0 after reset.
- Without the macro these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset: hold RST=0 for 2 cycles -> EMPTY=1, THREAD_EMPTY=1, FULL=0, THREAD_FULL=0, Q=0, THREAD_Q=0.
REQ-032 Down path: THREAD_ENQ one cycle with THREAD_D=0x100; when EMPTY=0, pulse DEQ -> Q=0x100 the next cycle, then EMPTY=1.
REQ-033 Up path, fill: ENQ 16 words 0..15 (CORAM_ADDR_LEN=4) -> FULL=1 after the 16th push; a 17th push of 0xFF is ignored; THREAD_DEQ x16 returns 0..15 in order, then THREAD_EMPTY=1.
REQ-034 Simultaneous push/pop: with 3 words in the down queue, assert THREAD_ENQ (0xAA) and DEQ at the same edge -> Q=first word, occupancy stays 3, and 0xAA is popped fourth.
REQ-035 Underflow and wrap: DEQ while EMPTY=1 -> Q unchanged; then run 40 push/pop pairs through the down queue -> data matches exactly, with no spurious FULL or EMPTY.
REQ-036 Reset mid-operation: with 5 words queued, pulse RST=0 for 1 cycle -> EMPTY=1 and Q=0; a subsequent push/pop returns only the new data.
